// File: rtl/stack_bus_upstream_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_bus_upstream_mux_pkg
// Description : Shared definitions for the stack-bus upstream path: framing
//               encodings, control-field width, FSM state encodings and a
//               helper for the source-ID width.
// Revision    : 1.0 - initial release
// ============================================================================
package stack_bus_upstream_mux_pkg;

    // Framing control field carried with every upstream word.
    localparam int         c_CNTL_W       = 2;
    localparam logic [1:0] c_CNTL_MOM     = 2'b00;
    localparam logic [1:0] c_CNTL_SOM     = 2'b01;
    localparam logic [1:0] c_CNTL_EOM     = 2'b10;
    localparam logic [1:0] c_CNTL_SOM_EOM = 2'b11;

    // SOM and EOM are independent flags inside the control field.
    localparam int c_SOM_BIT = 0;
    localparam int c_EOM_BIT = 1;

    // Upstream mux arbitration FSM.
    localparam int         c_STATE_W = 1;
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_XFER = 1'b1;

    // Source-ID width; never zero so a single-PE build still has a port.
    function automatic int id_width(input int num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stack_bus_upstream_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : stack_bus_upstream_mux_if
// Description : Bundle of the PE-side and stack-side upstream handshake
//               signals.
//               master : drives PE words and stack ready (PEs + stack side)
//               slave  : the upstream mux itself
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef PE_NUM_OF_PE
`define PE_NUM_OF_PE 8
`endif
interface stack_bus_upstream_mux_if
    import stack_bus_upstream_mux_pkg::*;
#(
    parameter int NUM_PE  = `PE_NUM_OF_PE,
    parameter int DATA_W  = 64,
    parameter int PE_ID_W = id_width(NUM_PE)
);
    logic [NUM_PE-1:0]          pe__stu__valid;
    logic [c_CNTL_W*NUM_PE-1:0] pe__stu__cntl;
    logic [DATA_W*NUM_PE-1:0]   pe__stu__data;
    logic [NUM_PE-1:0]          stu__pe__ready;
    logic                       stu__stack__valid;
    logic [c_CNTL_W-1:0]        stu__stack__cntl;
    logic [DATA_W-1:0]          stu__stack__data;
    logic [PE_ID_W-1:0]         stu__stack__peId;
    logic                       stack__stu__ready;

    modport master (
        output pe__stu__valid, pe__stu__cntl, pe__stu__data, stack__stu__ready,
        input  stu__pe__ready, stu__stack__valid, stu__stack__cntl,
               stu__stack__data, stu__stack__peId
    );

    modport slave (
        input  pe__stu__valid, pe__stu__cntl, pe__stu__data, stack__stu__ready,
        output stu__pe__ready, stu__stack__valid, stu__stack__cntl,
               stu__stack__data, stu__stack__peId
    );
endinterface
`default_nettype wire

// File: rtl/stack_bus_upstream_mux_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stu_fifo
// Description : Small synchronous FIFO buffering upstream words.
//               clk/rst   : clock, async active-high reset of pointers/count
//               push/wdata: write port (ignored when full)
//               pop/rdata : read port, rdata shows the head combinationally
//               full/empty: occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module stu_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] wdata,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign full   = (r_count == c_CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign rdata  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stack_bus_upstream_mux.sv
`default_nettype none
// ============================================================================
// Module      : stack_bus_upstream_mux
// Description : Round-robin, packet-locked multiplexer of NUM_PE upstream PE
//               word streams onto a single stack upstream port, buffered by
//               a FIFO_DEPTH-entry output FIFO.
//               clk                     : clock, rising edge
//               reset_poweron           : async active-high reset
//               bus (slave)             : PE inputs/readies, stack outputs
//               stu__sys__busy          : FSM active or FIFO non-empty
//               stu__sys__protocolError : sticky framing error flag
//               Optional macro STU_PROTOCOL_CHECK_EN enables the framing
//               check; otherwise stu__sys__protocolError is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef PE_NUM_OF_PE
`define PE_NUM_OF_PE 8
`endif
module stack_bus_upstream_mux
    import stack_bus_upstream_mux_pkg::*;
#(
    parameter int NUM_PE     = `PE_NUM_OF_PE,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int PE_ID_W    = id_width(NUM_PE)
) (
    input  wire logic                  clk,
    input  wire logic                  reset_poweron,
    stack_bus_upstream_mux_if.slave    bus,
    output logic                       stu__sys__busy,
    output logic                       stu__sys__protocolError
);
    localparam int c_FIFO_W = c_CNTL_W + DATA_W + PE_ID_W;

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;
    logic [PE_ID_W-1:0]   r_grant;
    logic [PE_ID_W-1:0]   w_rr_pick;
    logic                 w_rr_found;
    int                   w_idx;
    logic                 w_any_valid;
    logic                 w_sel_valid;
    logic [c_CNTL_W-1:0]  w_sel_cntl;
    logic [DATA_W-1:0]    w_sel_data;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [c_FIFO_W-1:0]  w_head;

    assign w_any_valid = |bus.pe__stu__valid;

    // Round-robin pick: first valid PE after the last grant, wrapping.
    always_comb begin
        w_rr_pick  = r_grant;
        w_rr_found = 1'b0;
        w_idx      = 0;
        for (int off = 1; off <= NUM_PE; off++) begin
            w_idx = (int'(r_grant) + off) % NUM_PE;
            if (!w_rr_found && bus.pe__stu__valid[w_idx]) begin
                w_rr_pick  = PE_ID_W'(w_idx);
                w_rr_found = 1'b1;
            end
        end
    end

    // Select the granted PE's word.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_cntl  = '0;
        w_sel_data  = '0;
        for (int g = 0; g < NUM_PE; g++) begin
            if (r_grant == PE_ID_W'(g)) begin
                w_sel_valid = bus.pe__stu__valid[g];
                w_sel_cntl  = bus.pe__stu__cntl[c_CNTL_W*g +: c_CNTL_W];
                w_sel_data  = bus.pe__stu__data[DATA_W*g +: DATA_W];
            end
        end
    end

    assign w_push = (r_state == c_ST_XFER) & w_sel_valid & ~w_full;
    assign w_pop  = ~w_empty & bus.stack__stu__ready;

    // FSM: state register. The grant is latched only when leaving IDLE
    // and then held for the whole message.
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            r_state <= c_ST_IDLE;
            r_grant <= PE_ID_W'(NUM_PE - 1);
        end else begin
            r_state <= w_next_state;
            if ((r_state == c_ST_IDLE) && w_any_valid) begin
                r_grant <= w_rr_pick;
            end
        end
    end

    // FSM: next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (w_any_valid) w_next_state = c_ST_XFER;
            c_ST_XFER: if (w_push && w_sel_cntl[c_EOM_BIT]) w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        bus.stu__pe__ready = '0;
        for (int g = 0; g < NUM_PE; g++) begin
            bus.stu__pe__ready[g] = (r_state == c_ST_XFER) &&
                                    (r_grant == PE_ID_W'(g)) && !w_full;
        end
        stu__sys__busy = (r_state != c_ST_IDLE) || !w_empty;
    end

    stu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset_poweron),
        .push  (w_push),
        .wdata ({w_sel_cntl, w_sel_data, r_grant}),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Head fields are masked while empty so the port reads zero after reset
    // even though FIFO storage is not reset.
    assign bus.stu__stack__valid = ~w_empty;
    assign bus.stu__stack__cntl  = w_empty ? '0 : w_head[c_FIFO_W-1 -: c_CNTL_W];
    assign bus.stu__stack__data  = w_empty ? '0 : w_head[PE_ID_W +: DATA_W];
    assign bus.stu__stack__peId  = w_empty ? '0 : w_head[PE_ID_W-1:0];

`ifdef STU_PROTOCOL_CHECK_EN
    logic r_first_word;
    logic r_proto_err;

    // A word must carry SOM exactly when it is the first of its message.
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            r_first_word <= 1'b1;
            r_proto_err  <= 1'b0;
        end else begin
            if (r_state == c_ST_IDLE) begin
                r_first_word <= 1'b1;
            end else if (w_push) begin
                r_first_word <= 1'b0;
            end
            if (w_push && (r_first_word != w_sel_cntl[c_SOM_BIT])) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign stu__sys__protocolError = r_proto_err;
`else
    assign stu__sys__protocolError = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stack_bus_upstream_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_bus_upstream_mux
// Description : Directed testbench for stack_bus_upstream_mux. Expected
//               words are queued by hand in arrival order; a monitor pops
//               and compares whenever the stack port handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_bus_upstream_mux;
    localparam int NUM_PE     = 8;
    localparam int DATA_W     = 64;
    localparam int FIFO_DEPTH = 4;
    localparam int PE_ID_W    = 3;

    typedef struct packed {
        logic [1:0]        c;
        logic [DATA_W-1:0] d;
    } word_t;

    typedef struct packed {
        logic [1:0]         c;
        logic [DATA_W-1:0]  d;
        logic [PE_ID_W-1:0] id;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     busy;
    logic                     perr;
    logic [NUM_PE-1:0]        pe_valid = '0;
    logic [2*NUM_PE-1:0]      pe_cntl = '0;
    logic [DATA_W*NUM_PE-1:0] pe_data = '0;
    logic                     stack_ready = 1'b1;

    stack_bus_upstream_mux_if #(
        .NUM_PE  (NUM_PE),
        .DATA_W  (DATA_W),
        .PE_ID_W (PE_ID_W)
    ) bus ();

    assign bus.pe__stu__valid    = pe_valid;
    assign bus.pe__stu__cntl     = pe_cntl;
    assign bus.pe__stu__data     = pe_data;
    assign bus.stack__stu__ready = stack_ready;

    stack_bus_upstream_mux #(
        .NUM_PE     (NUM_PE),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PE_ID_W    (PE_ID_W)
    ) dut (
        .clk                     (clk),
        .reset_poweron           (rst),
        .bus                     (bus),
        .stu__sys__busy          (busy),
        .stu__sys__protocolError (perr)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    word_t peq [NUM_PE][$];
    exp_t  sb[$];
    int    first_acc;
    int    last_acc;
    int    stall_acc;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_word(input int p, input logic [1:0] c, input logic [DATA_W-1:0] d);
        peq[p].push_back({c, d});
    endtask

    task automatic expect_word(input logic [1:0] c, input logic [DATA_W-1:0] d, input int id);
        sb.push_back({c, d, PE_ID_W'(id)});
    endtask

    function automatic bit pending();
        for (int p = 0; p < NUM_PE; p++) begin
            if (peq[p].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Scoreboard monitor plus back-pressure stability check.
    logic prev_hold = 1'b0;
    exp_t prev_out;
    always @(negedge clk) begin
        exp_t cur;
        exp_t e;
        cur = {bus.stu__stack__cntl, bus.stu__stack__data, bus.stu__stack__peId};
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", bus.stu__stack__valid, 1);
                check("hold_word", cur, prev_out);
            end
            if (bus.stu__stack__valid && stack_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got 0x%0h expected none", cur);
                end else begin
                    e = sb.pop_front();
                    check("out_cntl", cur.c, e.c);
                    check("out_data", cur.d, e.d);
                    check("out_peid", cur.id, e.id);
                end
            end
            prev_hold = bus.stu__stack__valid && !stack_ready;
            prev_out  = cur;
        end
    end

    // Presents queued PE words, holds the stack not-ready for `stall` cycles,
    // and records acceptance cycles relative to the call.
    task automatic run_traffic(input int stall, input int budget);
        int                n;
        logic [NUM_PE-1:0] acc;
        n         = 0;
        first_acc = -1;
        last_acc  = -1;
        stall_acc = 0;
        while ((pending() || sb.size() != 0) && n < budget) begin
            stack_ready = (n >= stall);
            for (int p = 0; p < NUM_PE; p++) begin
                if (peq[p].size() != 0) begin
                    pe_valid[p]              = 1'b1;
                    pe_cntl[2*p +: 2]        = peq[p][0].c;
                    pe_data[DATA_W*p +: DATA_W] = peq[p][0].d;
                end else begin
                    pe_valid[p]              = 1'b0;
                    pe_cntl[2*p +: 2]        = '0;
                    pe_data[DATA_W*p +: DATA_W] = '0;
                end
            end
            @(negedge clk);
            acc = pe_valid & bus.stu__pe__ready;
            check("ready_onehot", $countones(bus.stu__pe__ready) <= 1, 1);
            @(posedge clk);
            #1;
            for (int p = 0; p < NUM_PE; p++) begin
                if (acc[p]) begin
                    void'(peq[p].pop_front());
                    if (n < stall) stall_acc++;
                    if (first_acc < 0) first_acc = n;
                    last_acc = n;
                end
            end
            n++;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("FAIL traffic_timeout: got %0d cycles expected under %0d", n, budget);
            for (int p = 0; p < NUM_PE; p++) peq[p].delete();
            sb.delete();
        end
        pe_valid    = '0;
        pe_cntl     = '0;
        pe_data     = '0;
        stack_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.stu__pe__ready, 0);
        check("rst_valid", bus.stu__stack__valid, 0);
        check("rst_cntl", bus.stu__stack__cntl, 0);
        check("rst_data", bus.stu__stack__data, 0);
        check("rst_peid", bus.stu__stack__peId, 0);
        check("rst_busy", busy, 0);
        check("rst_perr", perr, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // PE3 single-word message, 1-cycle output latency after acceptance
        pe_valid[3]        = 1'b1;
        pe_cntl[7:6]       = 2'b11;
        pe_data[3*64 +: 64] = 64'hA5;
        expect_word(2'b11, 64'hA5, 3);
        waited = 0;
        @(negedge clk);
        while (!bus.stu__pe__ready[3] && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        check("grant_latency", waited, 1);
        @(posedge clk);
        #1;
        pe_valid = '0;
        pe_cntl  = '0;
        pe_data  = '0;
        check("pe3_valid", bus.stu__stack__valid, 1);
        check("pe3_peid", bus.stu__stack__peId, 3);
        check("pe3_data", bus.stu__stack__data, 64'hA5);
        check("pe3_cntl", bus.stu__stack__cntl, 2'b11);
        check("pe3_busy", busy, 1);
        repeat (2) @(posedge clk);
        #1;
        check("pe3_idle_busy", busy, 0);

        // Two single-word messages: one idle cycle between them
        add_word(4, 2'b11, 64'h40);
        add_word(4, 2'b11, 64'h41);
        expect_word(2'b11, 64'h40, 4);
        expect_word(2'b11, 64'h41, 4);
        run_traffic(0, 50);
        check("single_gap", last_acc - first_acc, 2);

        // Four-word message at full throughput
        add_word(6, 2'b01, 64'h60);
        add_word(6, 2'b00, 64'h61);
        add_word(6, 2'b00, 64'h62);
        add_word(6, 2'b10, 64'h63);
        for (int i = 0; i < 4; i++) expect_word((i == 0) ? 2'b01 : (i == 3) ? 2'b10 : 2'b00, 64'h60 + i, 6);
        run_traffic(0, 50);
        check("throughput", last_acc - first_acc, 3);

        // Round robin: last grant PE0, then PE0 and PE5 compete -> PE5 first
        add_word(0, 2'b11, 64'h0F);
        expect_word(2'b11, 64'h0F, 0);
        run_traffic(0, 50);
        add_word(0, 2'b01, 64'h100);
        add_word(0, 2'b10, 64'h101);
        add_word(5, 2'b01, 64'h500);
        add_word(5, 2'b10, 64'h501);
        expect_word(2'b01, 64'h500, 5);
        expect_word(2'b10, 64'h501, 5);
        expect_word(2'b01, 64'h100, 0);
        expect_word(2'b10, 64'h101, 0);
        run_traffic(0, 50);
        check("rr_span", last_acc - first_acc, 4);

        // Back-pressure: four-word message into a stalled stack
        add_word(2, 2'b01, 64'h200);
        add_word(2, 2'b00, 64'h201);
        add_word(2, 2'b00, 64'h202);
        add_word(2, 2'b10, 64'h203);
        for (int i = 0; i < 4; i++) expect_word((i == 0) ? 2'b01 : (i == 3) ? 2'b10 : 2'b00, 64'h200 + i, 2);
        run_traffic(6, 60);
        check("stall_fill4", stall_acc, 4);

        // Back-pressure: six-word message, PE ready must drop at full
        for (int i = 0; i < 6; i++) begin
            add_word(2, (i == 0) ? 2'b01 : (i == 5) ? 2'b10 : 2'b00, 64'h210 + i);
            expect_word((i == 0) ? 2'b01 : (i == 5) ? 2'b10 : 2'b00, 64'h210 + i, 2);
        end
        run_traffic(6, 60);
        check("stall_fill6", stall_acc, 4);

        // Message whose first word lacks SOM
        add_word(1, 2'b00, 64'h110);
        add_word(1, 2'b10, 64'h111);
        expect_word(2'b00, 64'h110, 1);
        expect_word(2'b10, 64'h111, 1);
        run_traffic(0, 50);
`ifdef STU_PROTOCOL_CHECK_EN
        check("perr_set", perr, 1);
`else
        check("perr_tied", perr, 0);
`endif
        add_word(1, 2'b11, 64'h112);
        expect_word(2'b11, 64'h112, 1);
        run_traffic(0, 50);
`ifdef STU_PROTOCOL_CHECK_EN
        check("perr_sticky", perr, 1);
`else
        check("perr_tied2", perr, 0);
`endif

        // Reset during word 2 of a 3-word message
        pe_valid[1]         = 1'b1;
        pe_cntl[3:2]        = 2'b01;
        pe_data[1*64 +: 64] = 64'h120;
        waited = 0;
        @(negedge clk);
        while (!bus.stu__pe__ready[1] && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        check("mid_grant", bus.stu__pe__ready[1], 1);
        @(posedge clk);
        #1;
        pe_cntl[3:2]        = 2'b00;
        pe_data[1*64 +: 64] = 64'h121;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", bus.stu__stack__valid, 0);
        check("mid_rst_ready", bus.stu__pe__ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cntl", bus.stu__stack__cntl, 0);
        check("mid_rst_data", bus.stu__stack__data, 0);
        check("mid_rst_peid", bus.stu__stack__peId, 0);
        pe_valid = '0;
        pe_cntl  = '0;
        pe_data  = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", bus.stu__stack__valid, 0);
        check("post_rst_perr", perr, 0);

        // Fresh message after reset: only this word may appear
        add_word(6, 2'b11, 64'h600);
        expect_word(2'b11, 64'h600, 6);
        run_traffic(0, 50);
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        check("final_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stack_bus_upstream_mux.md
STACK_BUS_UPSTREAM_MUX -- requirements
Module: stack_bus_upstream_mux

Interface
REQ-001 SHALL have parameter NUM_PE, default `PE_NUM_OF_PE, meaning number of PE upstream sources.
REQ-002 SHALL have parameter DATA_W, default 64, meaning upstream data word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of 2), meaning output buffer entries.
REQ-004 SHALL have parameter PE_ID_W, default clog2(NUM_PE), meaning source-ID width.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset_poweron  input  1  reset, asynchronous, active-high.
REQ-007 pe__stu__valid  input  NUM_PE  per-PE word valid.
REQ-008 pe__stu__cntl  input  2*NUM_PE  per-PE framing: 01=SOM, 00=MOM, 10=EOM, 11=SOM+EOM.
REQ-009 pe__stu__data  input  DATA_W*NUM_PE  per-PE data, PE i at slice i.
REQ-010 stu__pe__ready  output  NUM_PE  per-PE word accepted when valid&ready.
REQ-011 stu__stack__valid  output  1  stack upstream word valid.
REQ-012 stu__stack__cntl  output  2  framing, same encoding as inputs.
REQ-013 stu__stack__data  output  DATA_W  upstream data.
REQ-014 stu__stack__peId  output  PE_ID_W  source PE of the word.
REQ-015 stack__stu__ready  input  1  stack accepts word when valid&ready.
REQ-016 stu__sys__busy  output  1  high when FSM not IDLE or FIFO non-empty.

Function
REQ-017 FSM states IDLE, XFER; IDLE->XFER when any pe__stu__valid high; XFER->IDLE on accepting a word with EOM bit set.
REQ-018 In IDLE, grant SHALL be chosen round-robin: lowest valid PE index above the last granted index, wrapping to 0.
REQ-019 Grant SHALL be registered and held for the whole message (packet lock); no other PE gets ready during XFER.
REQ-020 stu__pe__ready[g] SHALL equal (state==XFER) & grant==g & FIFO not full; all other bits 0.
REQ-021 Accepted word SHALL be written to FIFO with {cntl, data, grant}; it appears on outputs the next cycle (1-cycle latency) when FIFO was empty.
REQ-022 stu__stack__valid SHALL equal FIFO non-empty; outputs reflect FIFO head; head pops on valid&stack__stu__ready.
REQ-023 Simultaneous push and pop SHALL keep occupancy unchanged; push on full is impossible by REQ-020; pop on empty impossible by REQ-022.
REQ-024 Full throughput: with stack__stu__ready held high, one word per cycle SHALL be sustained in XFER.
REQ-025 Single-word message (cntl=11) SHALL return FSM to IDLE; next grant evaluated the following cycle (one idle cycle between messages).
REQ-026 Stack back-pressure SHALL NOT alter outputs while valid&!ready (stable hold).

Reset
REQ-027 On reset_poweron high, asynchronously: state=IDLE, last-grant=NUM_PE-1 (PE0 first priority), FIFO pointers/count=0.
REQ-028 Reset values: stu__pe__ready=0, stu__stack__valid=0, cntl=0, data=0, peId=0, stu__sys__busy=0, error=0.
REQ-029 Reset mid-message SHALL discard FIFO contents and the partial message; no EOM is synthesised.

Configuration
REQ-030 Macro STU_PROTOCOL_CHECK_EN defined: output stu__sys__protocolError (1 bit) SHALL set sticky when a granted message's first word lacks SOM or a subsequent word carries SOM; cleared only by reset.
REQ-031 Macro undefined: port stu__sys__protocolError SHALL be present and tied 0; no check logic.

Structure
REQ-032 Framing encodings (SOM/MOM/EOM/SOM+EOM), cntl width and FSM state encodings SHALL live in the shared stack-bus upstream include/package.
REQ-033 FIFO SHALL be a sub-module stu_fifo (parameters DEPTH, WIDTH; push/pop/full/empty).

Verification
REQ-034 Reset then PE3 sends 1-word msg cntl=11 data=0xA5 -> next cycle valid=1, peId=3, data=0xA5, cntl=11.
REQ-035 PE0 and PE5 valid together, last grant PE0 -> PE5 message completes before PE0 gets ready.
REQ-036 PE2 sends 4-word msg (01,00,00,10), stack ready low for 6 cycles -> PE2 ready drops after 4 FIFO entries; all 4 words out in order after ready.
REQ-037 Assert reset_poweron during word 2 of a 3-word msg -> outputs 0 within same cycle, busy=0, FIFO empty.
REQ-038 With STU_PROTOCOL_CHECK_EN, PE1 first word cntl=00 -> protocolError=1 and stays 1 until reset.
